// File: rtl/duck_pkg.sv
// Shared definitions for the duck-hunt video blocks: sprite geometry, scan line
// and the hit-arbiter state encoding.
package duck_pkg;

  localparam int NUM_SLOTS      = 8;
  localparam int SLOT_W         = 3;
  localparam int COORD_W        = 12;
  localparam int SCORE_W        = 8;

  localparam int DUCK_W_DEF     = 124;
  localparam int DUCK_H_DEF     = 162;
  localparam int BULLET_W_DEF   = 4;
  localparam int BULLET_H_DEF   = 8;
  localparam int START_LINE_DEF = 481;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2,
    ST_LOCK   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/hit_arbiter_if.sv
// Bundle between the video timing / sprite blocks and the hit arbiter.
// The master side supplies raster position and sprite coordinates; the slave reports hits.
interface hit_arbiter_if;

  logic [9:0]                          hcount;
  logic [9:0]                          vcount;
  logic [10:0]                         duck_x;
  logic [9:0]                          duck_y;
  logic [duck_pkg::NUM_SLOTS*10-1:0]   bullet_x;
  logic [duck_pkg::NUM_SLOTS*10-1:0]   bullet_y;
  logic                                collision;
  logic                                kill_valid;
  logic [duck_pkg::SLOT_W-1:0]         kill_slot;
  logic [duck_pkg::SCORE_W-1:0]        score;
  logic                                busy;

  modport master (
    output hcount, vcount, duck_x, duck_y, bullet_x, bullet_y,
    input  collision, kill_valid, kill_slot, score, busy
  );

  modport slave (
    input  hcount, vcount, duck_x, duck_y, bullet_x, bullet_y,
    output collision, kill_valid, kill_slot, score, busy
  );

endinterface

// File: rtl/rect_overlap.sv
// Combinational axis-aligned overlap test between rectangle A (at ax,ay) and B (at bx,by).
// Coordinates are 12 bits wide so position + size never wraps.
module rect_overlap #(
  parameter int A_W = duck_pkg::DUCK_W_DEF,
  parameter int A_H = duck_pkg::DUCK_H_DEF,
  parameter int B_W = duck_pkg::BULLET_W_DEF,
  parameter int B_H = duck_pkg::BULLET_H_DEF
) (
  input  logic [duck_pkg::COORD_W-1:0] ax,
  input  logic [duck_pkg::COORD_W-1:0] ay,
  input  logic [duck_pkg::COORD_W-1:0] bx,
  input  logic [duck_pkg::COORD_W-1:0] by,
  output logic                         hit
);

  localparam logic [duck_pkg::COORD_W-1:0] A_W_C = duck_pkg::COORD_W'(A_W);
  localparam logic [duck_pkg::COORD_W-1:0] A_H_C = duck_pkg::COORD_W'(A_H);
  localparam logic [duck_pkg::COORD_W-1:0] B_W_C = duck_pkg::COORD_W'(B_W);
  localparam logic [duck_pkg::COORD_W-1:0] B_H_C = duck_pkg::COORD_W'(B_H);

  assign hit = (bx < ax + A_W_C) && (ax < bx + B_W_C) &&
               (by < ay + A_H_C) && (ay < by + B_H_C);

endmodule

// File: rtl/hit_arbiter.sv
// Once-per-frame bullet/duck collision arbiter: scans all bullet slots serially during
// vertical blanking and reports at most one hit (lowest slot wins), then locks out.
//   state  | meaning
//   IDLE   | waiting for the scan line; snapshots duck position on start
//   SCAN   | compares one bullet slot per cycle, slot_idx 0..NUM_SLOTS-1
//   REPORT | issues collision/kill/score update if a hit was found
//   LOCK   | counts down frames after a hit; no scan runs
module hit_arbiter
  import duck_pkg::*;
#(
  parameter int DUCK_W         = DUCK_W_DEF,
  parameter int DUCK_H         = DUCK_H_DEF,
  parameter int BULLET_W       = BULLET_W_DEF,
  parameter int BULLET_H       = BULLET_H_DEF,
  parameter int START_LINE     = START_LINE_DEF,
  parameter int LOCKOUT_FRAMES = 2
) (
  input  logic          vga_clk,
  input  logic          reset,
  hit_arbiter_if.slave  bus
);

  localparam int LOCK_W = (LOCKOUT_FRAMES < 2) ? 1 : $clog2(LOCKOUT_FRAMES + 1);

  arb_state_t              state_q, state_d;
  logic [COORD_W-1:0]      dx_q, dy_q;
  logic [SLOT_W-1:0]       slot_idx_q;
  logic                    hit_found_q;
  logic [SLOT_W-1:0]       hit_slot_q;
  logic [LOCK_W-1:0]       lock_cnt_q;
  logic                    collision_q, kill_valid_q, busy_q;
  logic [SLOT_W-1:0]       kill_slot_q;
  logic [SCORE_W-1:0]      score_q;

  logic                    start;
  logic [9:0]              bx_raw, by_raw;
  logic                    ovl_hit, slot_hit;
  logic                    rpt_fire, busy_d;

  assign start = (bus.vcount == 10'(START_LINE)) && (bus.hcount == 10'd0);

  // A single comparator is shared by all slots; the slot index steers its bullet inputs.
  assign bx_raw = bus.bullet_x[int'(slot_idx_q)*10 +: 10];
  assign by_raw = bus.bullet_y[int'(slot_idx_q)*10 +: 10];

  rect_overlap #(
    .A_W (DUCK_W),
    .A_H (DUCK_H),
    .B_W (BULLET_W),
    .B_H (BULLET_H)
  ) u_overlap (
    .ax  (dx_q),
    .ay  (dy_q),
    .bx  ({2'b00, bx_raw}),
    .by  ({2'b00, by_raw}),
    .hit (ovl_hit)
  );

  assign slot_hit = (by_raw != 10'd0) && ovl_hit;

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rpt_fire = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SCAN;
      ST_SCAN:   if (slot_idx_q == SLOT_W'(NUM_SLOTS - 1)) state_d = ST_REPORT;
      ST_REPORT: begin
        rpt_fire = hit_found_q;
        state_d  = (hit_found_q && (LOCKOUT_FRAMES != 0)) ? ST_LOCK : ST_IDLE;
      end
      ST_LOCK:   if (start && (lock_cnt_q <= LOCK_W'(1))) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // busy stays up through the cycle in which the report outputs are visible
    busy_d = (state_d == ST_SCAN) || (state_d == ST_REPORT) || (state_q == ST_REPORT);
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      dx_q         <= '0;
      dy_q         <= '0;
      slot_idx_q   <= '0;
      hit_found_q  <= 1'b0;
      hit_slot_q   <= '0;
      lock_cnt_q   <= '0;
      collision_q  <= 1'b0;
      kill_valid_q <= 1'b0;
      kill_slot_q  <= '0;
      score_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      collision_q  <= rpt_fire;
      kill_valid_q <= rpt_fire;
      busy_q       <= busy_d;
      if (rpt_fire) begin
        kill_slot_q <= hit_slot_q;
        score_q     <= (score_q == '1) ? score_q : score_q + SCORE_W'(1);
      end
      case (state_q)
        ST_IDLE: if (start) begin
          dx_q        <= {1'b0, bus.duck_x};
          dy_q        <= {2'b00, bus.duck_y};
          slot_idx_q  <= '0;
          hit_found_q <= 1'b0;
        end
        ST_SCAN: begin
          slot_idx_q <= slot_idx_q + SLOT_W'(1);
          if (slot_hit && !hit_found_q) begin
            hit_found_q <= 1'b1;
            hit_slot_q  <= slot_idx_q;
          end
        end
        ST_REPORT: if (rpt_fire) lock_cnt_q <= LOCK_W'(LOCKOUT_FRAMES);
        ST_LOCK:   if (start) lock_cnt_q <= lock_cnt_q - LOCK_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.collision  = collision_q;
  assign bus.kill_valid = kill_valid_q;
  assign bus.kill_slot  = kill_slot_q;
  assign bus.score      = score_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_hit_arbiter.sv
// Directed bench for hit_arbiter: each frame is one start cycle plus 12 observed cycles.
module tb_hit_arbiter;
  import duck_pkg::*;

  logic vga_clk = 1'b0;
  logic reset;
  always #5 vga_clk = ~vga_clk;

  hit_arbiter_if bus ();

  hit_arbiter dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [9:0] bx [8];
  logic [9:0] by [8];
  int         lock_left;
  logic [7:0] exp_score;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_bullets();
    for (int i = 0; i < 8; i++) begin
      bx[i] = '0;
      by[i] = '0;
    end
  endtask

  task automatic load_bullets();
    for (int i = 0; i < 8; i++) begin
      bus.bullet_x[i*10 +: 10] = bx[i];
      bus.bullet_y[i*10 +: 10] = by[i];
    end
  endtask

  // ov: hand-computed "some active slot overlaps the duck"; lockout tracked here.
  task automatic run_frame(input string tag, input bit ov, input logic [2:0] exp_slot);
    bit scan, hit;
    int pulses, kvs, busy_cyc, pulse_cyc;
    logic [2:0] got_slot;
    scan = (lock_left == 0);
    hit  = scan && ov;
    pulses = 0; kvs = 0; busy_cyc = 0; pulse_cyc = 0; got_slot = '0;
    load_bullets();
    bus.vcount = 10'd481;
    bus.hcount = 10'd0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge vga_clk);
      @(negedge vga_clk);
      if (c == 1) bus.hcount = 10'd1;
      if (bus.collision) begin pulses++; pulse_cyc = c; end
      if (bus.kill_valid) begin kvs++; got_slot = bus.kill_slot; end
      if (bus.busy) busy_cyc++;
    end
    if (hit) begin
      exp_score = (exp_score == 8'd255) ? 8'd255 : exp_score + 8'd1;
      lock_left = 2;
    end else if (!scan) begin
      lock_left--;
    end
    chk({tag, ".collision_pulses"}, pulses, hit ? 1 : 0);
    chk({tag, ".kill_pulses"}, kvs, hit ? 1 : 0);
    if (hit) begin
      chk({tag, ".pulse_cycle"}, pulse_cyc, 10);
      chk({tag, ".kill_slot"}, got_slot, exp_slot);
    end
    chk({tag, ".busy_cycles"}, busy_cyc, scan ? 10 : 0);
    chk({tag, ".score"}, bus.score, exp_score);
  endtask

  task automatic edge_case(input string tag, input logic [9:0] x, input logic [9:0] y, input bit ov);
    clear_bullets();
    bx[0] = x;
    by[0] = y;
    run_frame(tag, ov, 3'd0);
    while (lock_left != 0) run_frame({tag, "_lock"}, ov, 3'd0);
  endtask

  initial begin
    int pulses;
    reset      = 1'b0;
    bus.hcount = '0;
    bus.vcount = '0;
    bus.duck_x = '0;
    bus.duck_y = '0;
    clear_bullets();
    load_bullets();
    lock_left  = 0;
    exp_score  = '0;

    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("rst.collision", bus.collision, 0);
    chk("rst.kill_valid", bus.kill_valid, 0);
    chk("rst.kill_slot", bus.kill_slot, 0);
    chk("rst.score", bus.score, 0);
    chk("rst.busy", bus.busy, 0);
    reset = 1'b1;
    @(negedge vga_clk);

    // Single hit in slot 3, held for six frames: hits land on frames 0 and 3.
    bus.duck_x = 11'd100;
    bus.duck_y = 10'd200;
    bx[3] = 10'd150;
    by[3] = 10'd250;
    for (int f = 0; f < 6; f++) run_frame($sformatf("lock_f%0d", f), 1'b1, 3'd3);
    chk("lock.total_score", bus.score, 2);

    // Priority: slots 2, 5 and 7 overlap
    clear_bullets();
    bx[2] = 10'd110; by[2] = 10'd210;
    bx[5] = 10'd200; by[5] = 10'd300;
    bx[7] = 10'd220; by[7] = 10'd355;
    run_frame("prio", 1'b1, 3'd2);
    while (lock_left != 0) run_frame("prio_lock", 1'b1, 3'd2);

    // Horizontal and vertical adjacency around duck at (100,200)
    edge_case("x_right_out", 10'd224, 10'd250, 1'b0);
    edge_case("x_right_in",  10'd223, 10'd250, 1'b1);
    edge_case("x_left_out",  10'd96,  10'd250, 1'b0);
    edge_case("x_left_in",   10'd97,  10'd250, 1'b1);
    edge_case("y_bot_out",   10'd150, 10'd362, 1'b0);
    edge_case("y_bot_in",    10'd150, 10'd361, 1'b1);
    edge_case("y_top_out",   10'd150, 10'd192, 1'b0);
    edge_case("y_top_in",    10'd150, 10'd193, 1'b1);

    // y==0 marks an inactive slot even where it would geometrically overlap
    bus.duck_y = 10'd0;
    edge_case("inactive_y0", 10'd120, 10'd0, 1'b0);
    edge_case("active_y1",   10'd120, 10'd1, 1'b1);
    bus.duck_y = 10'd200;

    // Reset asserted at T+5 with a hit pending in slot 4
    clear_bullets();
    bx[4] = 10'd150; by[4] = 10'd250;
    load_bullets();
    bus.vcount = 10'd481;
    bus.hcount = 10'd0;
    @(posedge vga_clk);
    @(negedge vga_clk);
    bus.hcount = 10'd1;
    repeat (4) @(posedge vga_clk);
    @(negedge vga_clk);
    reset = 1'b0;
    #1;
    chk("midrst.busy", bus.busy, 0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge vga_clk);
      if (bus.collision || bus.kill_valid) pulses++;
    end
    chk("midrst.pulses", pulses, 0);
    chk("midrst.score", bus.score, 0);
    reset = 1'b1;
    @(negedge vga_clk);
    exp_score = '0;
    lock_left = 0;
    run_frame("post_rst", 1'b1, 3'd4);
    chk("post_rst.score_abs", bus.score, 1);

    // Saturation: drive the score up to 255, then one more hit
    while (exp_score != 8'd255) run_frame("sat_pre", 1'b1, 3'd4);
    while (lock_left != 0) run_frame("sat_pre_lock", 1'b1, 3'd4);
    chk("sat.preload_score", bus.score, 255);
    run_frame("sat", 1'b1, 3'd4);
    chk("sat.score_abs", bus.score, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
